// File: rtl/pixel_mem_bridge.sv
// Processor data-memory bridge: a word RAM plus an MMIO window that feeds an 8-bit pixel FIFO.
// Optional build macro PIXEL_DROP_CNT_EN adds a 16-bit saturating counter of rejected pushes.
module pixel_mem_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwe,
  input  logic [31:0] memAddr,
  input  logic [31:0] memDataIn,
  output logic [31:0] memDataOut,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  input  logic        pix_ready
);

  localparam int unsigned PtrW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned RamWords = (2 ** ADDR_WIDTH) - 256;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_mmio;
  logic [7:0]            mmio_off;
  logic                  unused_addr;

  assign addr        = memAddr[ADDR_WIDTH-1:0];
  assign is_mmio     = &addr[ADDR_WIDTH-1:8];
  assign mmio_off    = addr[7:0];
  assign unused_addr = ^memAddr[31:ADDR_WIDTH];

  // RAM: never reset; the read register has no reset so it maps onto block RAM.
  logic [31:0] ram_q [RamWords];
  logic [31:0] ram_rd_q;

  always_ff @(posedge clock) begin
    ram_rd_q <= ram_q[addr];
    if (mwe && !is_mmio) begin
      ram_q[addr] <= memDataIn;
    end
  end

  // Pixel FIFO
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            empty, full, push_req, push_acc, pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign push_req = mwe && is_mmio && (mmio_off == 8'h00);
  assign pop      = !empty && pix_ready;
  // When full, the slot being popped is the one the push overwrites.
  assign push_acc = push_req && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push_acc);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q;
    unique case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push_acc) begin
      fifo_q[wr_ptr_q] <= memDataIn[7:0];
    end
  end

  assign pix_valid = !empty;
  assign pix_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

  // Drop counter
  logic [31:0] drop_rd;

`ifdef PIXEL_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic        push_drop;

  assign push_drop = push_req && !push_acc;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_rd = {16'h0000, drop_cnt_q};
`else
  assign drop_rd = '0;
`endif

  // Read path
  logic [6:0]  count_ext;
  logic [31:0] mmio_rd_d, mmio_rd_q;
  logic        ram_sel_q;

  assign count_ext = 7'(count_q);

  always_comb begin
    mmio_rd_d = '0;
    if (is_mmio) begin
      unique case (mmio_off)
        8'h01:   mmio_rd_d = {24'h0, empty, full, count_ext[5:0]};
        8'h02:   mmio_rd_d = drop_rd;
        default: mmio_rd_d = '0;
      endcase
    end
  end

  // After reset the mux selects the cleared MMIO register so memDataOut reads 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      mmio_rd_q <= '0;
      ram_sel_q <= 1'b0;
    end else begin
      mmio_rd_q <= mmio_rd_d;
      ram_sel_q <= !is_mmio;
    end
  end

  assign memDataOut = ram_sel_q ? ram_rd_q : mmio_rd_q;

endmodule

// File: tb/tb_pixel_mem_bridge.sv
// Self-checking bench for pixel_mem_bridge: read-data and pixel scoreboards fed by a behavioural model.
module tb_pixel_mem_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic        mwe;
  logic [31:0] memAddr;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;

  pixel_mem_bridge #(
    .FIFO_DEPTH(8),
    .ADDR_WIDTH(12)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mwe       (mwe),
    .memAddr   (memAddr),
    .memDataIn (memDataIn),
    .memDataOut(memDataOut),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready)
  );

  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0]  mq [$];
  logic [31:0] rd_q [$];
  logic [31:0] ram_m [int];
  int unsigned drops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one cycle, updates the model, checks at the next posedge + 1.
  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] data,
                      input logic rdy, input logic chk);
    logic [11:0] a;
    logic [31:0] exp;
    logic        do_pop, do_push, acc;
    int          n;
    a         = addr[11:0];
    mwe       = we;
    memAddr   = addr;
    memDataIn = data;
    pix_ready = rdy;
    #1;
    n = mq.size();
    check("pix_valid", {31'b0, pix_valid}, {31'b0, n != 0});
    if (n != 0) check("pix_data", {24'b0, pix_data}, {24'b0, mq[0]});
    if (a < 12'hF00)       exp = ram_m.exists(int'(a)) ? ram_m[int'(a)] : 32'h0;
    else if (a == 12'hF01) exp = {24'h0, n == 0, n == 8, 6'(n)};
`ifdef PIXEL_DROP_CNT_EN
    else if (a == 12'hF02) exp = (drops > 32'hFFFF) ? 32'hFFFF : drops;
`endif
    else                   exp = 32'h0;
    if (chk) rd_q.push_back(exp);
    do_pop  = (n != 0) && rdy;
    do_push = we && (a == 12'hF00);
    acc     = do_push && ((n < 8) || do_pop);
    if (do_pop) void'(mq.pop_front());
    if (acc) mq.push_back(data[7:0]);
    if (do_push && !acc) drops++;
    if (we && (a < 12'hF00)) ram_m[int'(a)] = data;
    @(posedge clock);
    #1;
    if (rd_q.size() != 0) check($sformatf("rd[%03h]", a), memDataOut, rd_q.pop_front());
    @(negedge clock);
  endtask

  // Reset pulse with a push and a pop request presented at the same time.
  task automatic pulse_reset(input int cycles);
    reset     = 1'b1;
    mwe       = 1'b1;
    memAddr   = 32'h0000_0F00;
    memDataIn = 32'h0000_0055;
    pix_ready = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    check("rst_memDataOut", memDataOut, 32'h0);
    check("rst_pix_valid", {31'b0, pix_valid}, 32'h0);
    check("rst_pix_data", {24'b0, pix_data}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    mq.delete();
    drops = 0;
  endtask

  initial begin
    @(negedge clock);
    pulse_reset(2);
    step(0, 32'h0000_0F01, 0, 0, 1);                     // status after reset
    step(0, 32'h0000_0F02, 0, 0, 1);

    step(1, 32'h0000_0010, 32'hDEADBEEF, 0, 0);
    step(0, 32'h0000_0010, 0, 0, 1);
    step(0, 32'hABCD_0010, 0, 0, 1);                     // upper address bits ignored
    step(1, 32'h0000_0020, 32'h1234_5678, 0, 0);
    step(1, 32'h0000_0020, 32'hCAFE_F00D, 0, 1);         // read-before-write
    step(0, 32'h0000_0020, 0, 0, 1);
    step(1, 32'h0000_0EFF, 32'hA5A5_5A5A, 0, 0);         // last RAM word
    step(0, 32'h0000_0EFF, 0, 0, 1);

    step(0, 32'h0000_0F00, 0, 0, 1);
    step(0, 32'h0000_0F05, 0, 0, 1);
    step(1, 32'h0000_0F01, 32'hFF, 0, 0);
    step(1, 32'h0000_0F05, 32'hFF, 0, 0);
    step(0, 32'h0000_0F01, 0, 0, 1);

    // Push and pop in the same cycle on an empty FIFO
    step(1, 32'h0000_0F00, 32'h77, 1, 0);
    step(0, 32'h0000_0F01, 0, 0, 1);
    step(0, 32'h0000_0F01, 0, 1, 1);

    for (int i = 0; i < 8; i++) step(1, 32'h0000_0F00, 32'h11 + i, 0, 0);
    step(0, 32'h0000_0F01, 0, 0, 1);
    step(1, 32'h0000_0F00, 32'h99, 0, 0);
    step(1, 32'h0000_0F00, 32'h99, 0, 0);
    step(0, 32'h0000_0F02, 0, 0, 1);
    step(0, 32'h0000_0F01, 0, 0, 1);
    step(1, 32'h0000_0F00, 32'h99, 1, 0);
    step(0, 32'h0000_0F01, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 32'h0000_0F01, 0, 1, 1);
    step(0, 32'h0000_0F01, 0, 0, 1);

    for (int i = 0; i < 3; i++) step(1, 32'h0000_0F00, 32'h21 + i, 0, 0);
    step(0, 32'h0000_0F01, 0, 0, 1);
    pulse_reset(1);
    step(0, 32'h0000_0F01, 0, 0, 1);
    step(0, 32'h0000_0F02, 0, 0, 1);
    step(0, 32'h0000_0010, 0, 0, 1);
    step(0, 32'h0000_0020, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
